// File: rtl/pwm_multi_unit_if.sv
// Configuration and status bundle between the register/control side and
// the multi-channel PWM generator. Clock and reset stay outside the bundle.
interface pwm_multi_unit_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    // Control and staged configuration, driven by the register side
    logic                      pwm_en;
    logic                      pwm_update;
    logic                      pwm_center;
    logic [WIDTH-1:0]          pwm_range;
    logic [CHANNELS*WIDTH-1:0] pwm_value;
    logic [CHANNELS-1:0]       pwm_polarity;

    // Status and PWM outputs, driven by the generator
    logic                      pwm_pending;
    logic                      pwm_period;
    logic [WIDTH-1:0]          pwm_count;
    logic [CHANNELS-1:0]       pwm_out;

    modport master (
        output pwm_en,
        output pwm_update,
        output pwm_center,
        output pwm_range,
        output pwm_value,
        output pwm_polarity,
        input  pwm_pending,
        input  pwm_period,
        input  pwm_count,
        input  pwm_out
    );

    modport slave (
        input  pwm_en,
        input  pwm_update,
        input  pwm_center,
        input  pwm_range,
        input  pwm_value,
        input  pwm_polarity,
        output pwm_pending,
        output pwm_period,
        output pwm_count,
        output pwm_out
    );
endinterface

// File: rtl/pwm_multi_unit.sv
// Multi-channel PWM generator. One shared period counter (sawtooth or
// triangle) feeds CHANNELS duty comparators. Configuration is written into
// a staging copy and only copied into the active copy on a period boundary,
// so a running period is never disturbed by a register write.
module pwm_multi_unit #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic              pwm_clk,
    input  logic              pwm_reset,
    pwm_multi_unit_if.slave   bus
);

    typedef enum logic [0:0] {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [WIDTH-1:0]          CNT_ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]          CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]          RANGE_RST = {WIDTH{1'b1}};
    localparam logic [CHANNELS*WIDTH-1:0] VALUE_RST = {(CHANNELS*WIDTH){1'b0}};
    localparam logic [CHANNELS-1:0]       POL_RST   = {CHANNELS{1'b0}};

    // Counter and direction
    logic [WIDTH-1:0]          count_q,      count_d;
    dir_e                      dir_q,        dir_d;
    logic                      boundary_s;

    // Active configuration (what the comparators use right now)
    logic [WIDTH-1:0]          range_q,      range_d;
    logic [CHANNELS*WIDTH-1:0] value_q,      value_d;
    logic [CHANNELS-1:0]       pol_q,        pol_d;
    logic                      center_q,     center_d;

    // Staged configuration (waits for the next boundary)
    logic [WIDTH-1:0]          stg_range_q,  stg_range_d;
    logic [CHANNELS*WIDTH-1:0] stg_value_q,  stg_value_d;
    logic [CHANNELS-1:0]       stg_pol_q,    stg_pol_d;
    logic                      stg_center_q, stg_center_d;
    logic                      pending_q,    pending_d;

    // Registered outputs
    logic                      period_q,     period_d;
    logic [CHANNELS-1:0]       out_q,        out_d;
    logic [CHANNELS-1:0]       raw_s;

    // Counter sequencing: sawtooth or triangle, plus period boundary detect
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        if (!bus.pwm_en) begin
            count_d = count_q;
            dir_d   = dir_q;
        end else if (range_q == CNT_ZERO) begin
            // Degenerate range: counter parks at zero, every cycle is a boundary
            count_d = CNT_ZERO;
            dir_d   = DIR_UP;
        end else if (!center_q) begin
            if (count_q < range_q) begin
                count_d = count_q + CNT_ONE;
            end else begin
                count_d = CNT_ZERO;
            end
            dir_d = DIR_UP;
        end else begin
            case (dir_q)
                DIR_UP: begin
                    if (count_q < range_q) begin
                        count_d = count_q + CNT_ONE;
                    end else begin
                        // Peak reached: turn around without repeating R
                        count_d = range_q - CNT_ONE;
                        dir_d   = DIR_DOWN;
                    end
                end
                DIR_DOWN: begin
                    if (count_q > CNT_ONE) begin
                        count_d = count_q - CNT_ONE;
                    end else begin
                        count_d = CNT_ZERO;
                    end
                end
                default: begin
                    count_d = CNT_ZERO;
                    dir_d   = DIR_UP;
                end
            endcase
        end

        boundary_s = bus.pwm_en && (count_d == CNT_ZERO);
        if (boundary_s) begin
            dir_d = DIR_UP;
        end else begin
            dir_d = dir_d;
        end
    end

    // Staging capture and boundary-time transfer into the active configuration
    always_comb begin
        range_d      = range_q;
        value_d      = value_q;
        pol_d        = pol_q;
        center_d     = center_q;
        stg_range_d  = stg_range_q;
        stg_value_d  = stg_value_q;
        stg_pol_d    = stg_pol_q;
        stg_center_d = stg_center_q;
        pending_d    = pending_q;

        // The boundary consumes whatever was staged before this cycle's strobe
        if (boundary_s && pending_q) begin
            range_d   = stg_range_q;
            value_d   = stg_value_q;
            pol_d     = stg_pol_q;
            center_d  = stg_center_q;
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end

        // A strobe always lands in staging and leaves something pending
        if (bus.pwm_update) begin
            stg_range_d  = bus.pwm_range;
            stg_value_d  = bus.pwm_value;
            stg_pol_d    = bus.pwm_polarity;
            stg_center_d = bus.pwm_center;
            pending_d    = 1'b1;
        end else begin
            stg_range_d  = stg_range_q;
        end
    end

    // Duty comparison on the active configuration and output level selection
    always_comb begin
        raw_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            raw_s[i] = (value_q[i*WIDTH +: WIDTH] > count_q);
        end
        if (bus.pwm_en) begin
            out_d = pol_q ^ raw_s;
        end else begin
            // Counting stopped: drive the idle level
            out_d = pol_q;
        end
        period_d = boundary_s;
    end

    // State register; reset wins over every other update
    always_ff @(posedge pwm_clk) begin
        if (pwm_reset) begin
            count_q      <= CNT_ZERO;
            dir_q        <= DIR_UP;
            range_q      <= RANGE_RST;
            value_q      <= VALUE_RST;
            pol_q        <= POL_RST;
            center_q     <= 1'b0;
            stg_range_q  <= RANGE_RST;
            stg_value_q  <= VALUE_RST;
            stg_pol_q    <= POL_RST;
            stg_center_q <= 1'b0;
            pending_q    <= 1'b0;
            period_q     <= 1'b0;
            out_q        <= POL_RST;
        end else begin
            count_q      <= count_d;
            dir_q        <= dir_d;
            range_q      <= range_d;
            value_q      <= value_d;
            pol_q        <= pol_d;
            center_q     <= center_d;
            stg_range_q  <= stg_range_d;
            stg_value_q  <= stg_value_d;
            stg_pol_q    <= stg_pol_d;
            stg_center_q <= stg_center_d;
            pending_q    <= pending_d;
            period_q     <= period_d;
            out_q        <= out_d;
        end
    end

    assign bus.pwm_count   = count_q;
    assign bus.pwm_pending = pending_q;
    assign bus.pwm_period  = period_q;
    assign bus.pwm_out     = out_q;

endmodule

// File: doc/pwm_multi_unit.md
Name: pwm_multi_unit

Overview:
Parametrised multi-channel PWM generator: one shared period counter drives CHANNELS independent duty comparators.
- Supports edge-aligned (sawtooth) and center-aligned (triangle) counting.
- Has per-channel output polarity.
- Uses a staged/shadow configuration path, so new settings take effect only at a period boundary (glitch-free updates).
- Sits between the register/control interface and the pads/gate drivers.

Parameters:
WIDTH, 8, bit width of counter, range and duty values
CHANNELS, 4, number of PWM output channels

Ports:
pwm_clk  in  1  single clock; all logic on rising edge
pwm_reset  in  1  synchronous, active-high reset
pwm_en  in  1  global count enable
pwm_update  in  1  one-cycle strobe: capture config inputs into staging registers
pwm_center  in  1  mode for staged config: 0 = edge-aligned, 1 = center-aligned
pwm_range  in  WIDTH  staged period range R
pwm_value  in  CHANNELS*WIDTH  staged duty values; channel i at [i*WIDTH +: WIDTH]
pwm_polarity  in  CHANNELS  staged per-channel polarity; 1 inverts the output
pwm_pending  out  1  staged config not yet applied
pwm_period  out  1  one-cycle pulse at the start of each period
pwm_count  out  WIDTH  current counter value C
pwm_out  out  CHANNELS  PWM outputs

Behaviour:
- Reset (pwm_reset=1 at a clock edge) has priority over everything, including mid-period and while pending:
  - Registers: C=0, dir=up, pending=0, pwm_period=0, pwm_out=0.
  - Active and staged config: R=all-ones, values=0, polarity=0, mode=edge.
- pwm_en=0: C, dir and active config hold; no boundary; pwm_out = active polarity (idle level) one cycle later. Staging still accepts pwm_update.
- Counter next-state, when pwm_en=1:
  - Edge mode: C<R gives C+1; otherwise C becomes 0.
  - Center mode, dir up: C<R gives C+1; otherwise dir becomes down and C becomes R-1.
  - Center mode, dir down: C>1 gives C-1; otherwise C becomes 0.
- Boundary B = pwm_en && (next C == 0). On B: dir=up.
  - Edge period = R+1 cycles.
  - Center period = 2R cycles (sequence 0..R..1).
  - R=0 in either mode: C stays 0 and B fires every cycle.
- Config load on B: if pending, active config (R, values, polarity, mode) is loaded from staging and pending clears. A mode change therefore always starts a new period at C=0, dir=up.
- pwm_update: staging captures all config inputs and pending=1 next cycle.
  - Update while already pending overwrites staging; pending stays 1.
  - Update in the same cycle as B: B loads the old staging (if it was pending); the new values land in staging; pending ends at 1.
  - Update in the same cycle as B with no prior pending: B loads nothing; pending=1.
- Compare: raw_i = (V_i > C), evaluated on active config, WIDTH-bit unsigned.
- pwm_out[i] is registered: polarity_i ^ raw_i, one cycle latency after C.
- High cycles per period (polarity 0):
  - Edge mode: min(V, R+1).
  - Center mode: 0 for V=0; 2V-1 for 1<=V<=R; 2R for V>R.
- pwm_period is registered: high for exactly one cycle, the cycle after B, aligned with C=0 of the new period. pwm_count is C directly.
- All arithmetic is WIDTH-bit unsigned. No wrap past all-ones, since C never exceeds R.

Test Plan:
1. Reset for 2 cycles, then pwm_en=1 with no update -> pwm_out=0, pwm_pending=0, pwm_count runs 0..255, pwm_period pulses every 256 cycles.
2. Edge mode (WIDTH=8, CHANNELS=4): update R=9, values {0,3,10,255}, polarity 0 -> after the first boundary, pwm_period every 10 cycles; high counts per period {0,3,10,10}.
3. Center mode: update R=4, values {0,1,2,5}, polarity 4'b1000 -> period 8 cycles; high counts {0,1,3,8}; ch3 is inverted (low for all 8 cycles).
4. R=9 edge with ch0=3; update ch0=7 at C=5 -> current period keeps 3 high cycles, next period has 7; pwm_pending high from the cycle after the strobe until the cycle after B.
5. Pending config A (ch0=2) plus strobe B (ch0=6) on the boundary cycle -> A applied this period, pwm_pending stays 1, B applied at the following boundary.
6. Drop pwm_en at C=4 -> pwm_count frozen at 4, pwm_out = polarity after 1 cycle; re-enable -> resumes at 5. Then assert pwm_reset mid-period with pending=1 -> all outputs and registers at reset values next cycle, pending=0.
